// File: rtl/signed_mul_seq_display.sv
// Sequential signed 4x4 multiplier with a sign/tens/ones seven-segment readout.
// One start handshake runs three stages: a shift-add multiply on the operand
// magnitudes, a double-dabble binary-to-BCD conversion, and a single
// encode/commit cycle. Product and display change only on that commit edge.
module signed_mul_seq_display #(
    parameter bit BLANK_LEADING = 1'b1,
    parameter int MUL_STEPS     = 4,
    parameter int BCD_STEPS     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic signed [3:0] a,
    input  logic signed [3:0] b,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic        [7:0] product,
    output logic        [6:0] seg_sign,
    output logic        [6:0] seg_tens,
    output logic        [6:0] seg_ones
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_BCD,
        S_ENC
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [2:0] MUL_LAST  = 3'(MUL_STEPS - 1);
    localparam logic [2:0] BCD_LAST  = 3'(BCD_STEPS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  step_cnt;
    logic [3:0]  mplier;      // magnitude of b, consumed LSB first
    logic [6:0]  mcand;       // magnitude of a, shifted left each step
    logic [6:0]  acc;         // product magnitude, 0..64
    logic [6:0]  acc_nxt;
    logic        neg;
    logic [14:0] bcd_sr;      // {tens, ones, remaining magnitude bits}
    logic [14:0] bcd_adj;
    logic [3:0]  mag_a;
    logic [3:0]  mag_b;
    logic        accept;
    logic        last_step;

    // Active-low segment code for one decimal digit; anything else is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // |-8| is 4'b1000, which reads correctly as an unsigned 8.
    assign mag_a     = a[3] ? 4'(-a) : a;
    assign mag_b     = b[3] ? 4'(-b) : b;
    assign accept    = (state == S_IDLE) && start;
    assign last_step = (step_cnt == 3'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_MUL;
            S_MUL:   if (last_step) state_nxt = S_BCD;
            S_BCD:   if (last_step) state_nxt = S_ENC;
            S_ENC:                  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // One shift-add step and one double-dabble adjust step.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : 7'd0);
        bcd_adj = bcd_sr;
        if (bcd_sr[14:11] >= 4'd5) bcd_adj[14:11] = bcd_sr[14:11] + 4'd3;
        if (bcd_sr[10:7]  >= 4'd5) bcd_adj[10:7]  = bcd_sr[10:7]  + 4'd3;
    end

    // Datapath: operand latch, multiply iterations, BCD iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            bcd_sr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mplier   <= mag_b;
                        mcand    <= {3'd0, mag_a};
                        acc      <= '0;
                        neg      <= a[3] ^ b[3];
                        step_cnt <= MUL_LAST;
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    if (last_step) begin
                        // The last step's sum goes straight into the converter.
                        bcd_sr   <= {8'd0, acc_nxt};
                        step_cnt <= BCD_LAST;
                    end else begin
                        step_cnt <= step_cnt - 3'd1;
                    end
                end
                S_BCD: begin
                    bcd_sr <= bcd_adj << 1;
                    if (!last_step) step_cnt <= step_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake flags and the committed result/display, updated together at ENC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            product  <= 8'h00;
            seg_sign <= SEG_BLANK;
            seg_tens <= SEG_BLANK;
            seg_ones <= SEG_BLANK;
        end else begin
            done <= (state == S_ENC);
            if (accept) busy <= 1'b1;
            if (state == S_ENC) begin
                busy     <= 1'b0;
                valid    <= 1'b1;
                product  <= neg ? -{1'b0, acc} : {1'b0, acc};
                seg_sign <= (neg && acc != 7'd0) ? SEG_MINUS : SEG_BLANK;
                seg_tens <= (BLANK_LEADING && bcd_sr[14:11] == 4'd0)
                            ? SEG_BLANK : seg7(bcd_sr[14:11]);
                seg_ones <= seg7(bcd_sr[10:7]);
            end
        end
    end

endmodule

// File: tb/tb_signed_mul_seq_display.sv
// Directed bench for signed_mul_seq_display: two instances share stimulus, one
// with leading-zero blanking and one without.
module tb_signed_mul_seq_display;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic signed [3:0] a = '0;
    logic signed [3:0] b = '0;

    logic       busy, done, valid;
    logic [7:0] product;
    logic [6:0] seg_sign, seg_tens, seg_ones;

    logic       busy0, done0, valid0;
    logic [7:0] product0;
    logic [6:0] seg_sign0, seg_tens0, seg_ones0;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    signed_mul_seq_display #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .valid(valid), .product(product),
        .seg_sign(seg_sign), .seg_tens(seg_tens), .seg_ones(seg_ones)
    );

    signed_mul_seq_display #(.BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .valid(valid0), .product(product0),
        .seg_sign(seg_sign0), .seg_tens(seg_tens0), .seg_ones(seg_ones0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},     32'(busy),     32'(0));
        check({tag, " done"},     32'(done),     32'(0));
        check({tag, " valid"},    32'(valid),    32'(0));
        check({tag, " product"},  32'(product),  32'(0));
        check({tag, " seg_sign"}, 32'(seg_sign), 32'(BLANK));
        check({tag, " seg_tens"}, 32'(seg_tens), 32'(BLANK));
        check({tag, " seg_ones"}, 32'(seg_ones), 32'(BLANK));
    endtask

    // Issue one operation and wait for done. With inject set, start pulses
    // with a=1,b=1 are presented for the edges N+3 and N+8 while busy.
    task automatic run_op(input string tag, input logic signed [3:0] ta,
                          input logic signed [3:0] tb, input bit inject);
        int lat;
        int busy_cycles;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb;   // operand changes after the latch edge must not matter
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cycles++;
            start = inject && (lat == 2 || lat == 7);
            if (start) begin a = 4'sd1; b = 4'sd1; end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(12));
        check({tag, " busy cycles"}, 32'(busy_cycles), 32'(12));
        check({tag, " busy at done"}, 32'(busy), 32'(0));
        check({tag, " valid"}, 32'(valid), 32'(1));
    endtask

    task automatic expect_result(input string tag, input logic [7:0] p, input logic [6:0] s,
                                 input logic [6:0] t, input logic [6:0] o);
        check({tag, " product"},  32'(product),  32'(p));
        check({tag, " seg_sign"}, 32'(seg_sign), 32'(s));
        check({tag, " seg_tens"}, 32'(seg_tens), 32'(t));
        check({tag, " seg_ones"}, 32'(seg_ones), 32'(o));
    endtask

    initial begin
        int k;
        bit saw_done;

        // Reset state while rst_n is held low.
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle no start busy", 32'(busy), 32'(0));

        // 3 * -5 = -15
        run_op("3x-5", 4'sd3, -4'sd5, 1'b0);
        expect_result("3x-5", 8'hF1, MINUS, 7'b1111001, 7'b0010010);
        @(posedge clk); #1;
        check("3x-5 done one cycle", 32'(done), 32'(0));
        check("3x-5 hold product", 32'(product), 32'(8'hF1));

        // -8 * -8 = +64, no overflow
        run_op("-8x-8", -4'sd8, -4'sd8, 1'b0);
        expect_result("-8x-8", 8'h40, BLANK, 7'b0000010, 7'b0011001);

        // 7 * -8 = -56, most negative result
        run_op("7x-8", 4'sd7, -4'sd8, 1'b0);
        expect_result("7x-8", 8'hC8, MINUS, 7'b0010010, 7'b0000010);

        // 0 * -7: no minus sign on zero, tens blank or "0" by parameter
        run_op("0x-7", 4'sd0, -4'sd7, 1'b0);
        expect_result("0x-7", 8'h00, BLANK, BLANK, 7'b1000000);
        check("0x-7 noblank tens",  32'(seg_tens0), 32'(7'b1000000));
        check("0x-7 noblank sign",  32'(seg_sign0), 32'(BLANK));
        check("0x-7 noblank ones",  32'(seg_ones0), 32'(7'b1000000));
        check("0x-7 noblank prod",  32'(product0),  32'(0));

        // 7 * 7 with start pulses during busy, which must be ignored
        run_op("7x7 ignore", 4'sd7, 4'sd7, 1'b1);
        expect_result("7x7 ignore", 8'd49, BLANK, 7'b0011001, 7'b0011000);
        check("7x7 noblank tens", 32'(seg_tens0), 32'(7'b0011001));

        // start held high: done every 13 cycles, back-to-back
        @(negedge clk);
        a = 4'sd2; b = 4'sd3; start = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 30);
        check("b2b first done latency", 32'(k), 32'(13));
        check("b2b first product", 32'(product), 32'(6));
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 30);
        start = 1'b0;
        check("b2b interval", 32'(k), 32'(13));
        check("b2b second product", 32'(product), 32'(6));
        @(posedge clk); #1;
        check("b2b stopped busy", 32'(busy), 32'(0));

        // -3 * 4 aborted by reset mid-operation
        @(negedge clk);
        a = -4'sd3; b = 4'sd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        saw_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
        @(negedge clk); rst_n = 1'b1;
        repeat (14) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
        check("abort no done", 32'(saw_done), 32'(0));
        check("abort valid", 32'(valid), 32'(0));
        check("abort product", 32'(product), 32'(0));

        run_op("-3x4", -4'sd3, 4'sd4, 1'b0);
        expect_result("-3x4", 8'hF4, MINUS, 7'b1111001, 7'b0100100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
